vx_tcu_drl_mask_seq: RTL and testbench
======================================

Name: VX_tcu_drl_mask_seq

Overview:
- Multi-step lane-mask sequencer for the TCU DRL datapath.
- Accepts one `vld_mask` + format per operation and issues a stream of per-step TCK-lane masks.
  - One beat per step, valid/ready handshake on both sides.
  - Covers all chunks of `vld_mask` for the selected element width.
- Optionally skips steps with no active lanes.
- Sits between TCU operand dispatch and the DRL lane array.

Parameters:
- MAX_INPUTS, 32, width of `vld_mask`; must be a multiple of 4*TCK.
- N, 2, DRL half-width.
- TCK, 2*N, lanes per step.
- SKIP_EMPTY, 1, 1 = steps with an all-zero lane mask are not issued.
- MAX_STEPS, MAX_INPUTS/TCK, derived; sizes the step index and step-nonzero vector.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  operation request
- ready_in  out  1  sequencer can accept
- vld_mask  in  MAX_INPUTS  per-element valid mask
- fmt_s  in  4  TCU format ID
- valid_out  out  1  step beat valid
- ready_out  in  1  consumer accepts beat
- lane_mask  out  TCK  active lanes for this step
- step_idx  out  $clog2(MAX_STEPS)  chunk index of this beat
- last  out  1  final beat of the operation
- lane_cnt  out  $clog2(TCK+1)  popcount of `lane_mask`
- fmt_err  out  1  beat belongs to an unsupported `fmt_s`

Behaviour:
- Reset: state IDLE; `valid_out`, `last`, `fmt_err` = 0; `lane_mask`, `step_idx`, `lane_cnt` = 0; `ready_in` = 1 in the cycle after reset deasserts.
- Stride S and step count K per format:
  - FP32: S=4, odd lanes forced 0, K=MAX_INPUTS/(4*TCK).
  - FP16, BF16: S=4, K=MAX_INPUTS/(4*TCK).
  - FP8, BF8, I8, U8: S=2, K=MAX_INPUTS/(2*TCK).
  - I4, U4: S=1, K=MAX_INPUTS/TCK.
- Step s, lane i: `lane_mask[i] = vld_mask[s*S*TCK + i*S]`, with the FP32 odd-lane rule applied.
- Capture on accept (`valid_in && ready_in`): latch `vld_mask`, `fmt_s`, and a nonzero-vector `nz[K-1:0]` of per-step masks.
- Issue set:
  - SKIP_EMPTY=0: all steps 0..K-1.
  - SKIP_EMPTY=1: steps with `nz[s]=1`, ascending order.
  - Empty issue set (all-zero mask, or unsupported format): exactly one beat, `step_idx`=0, `lane_mask`=0, `lane_cnt`=0, `last`=1.
  - Unsupported `fmt_s` additionally sets `fmt_err`=1 on that beat; `fmt_err`=0 otherwise.
- FSM:
  - IDLE: on accept -> ISSUE.
  - ISSUE: on beat handshake with `last`=1 -> IDLE, or stay in ISSUE if a new accept happens in the same cycle.
- `ready_in` = (state==IDLE) || (`valid_out` && `ready_out` && `last`), giving back-to-back operations with no bubble.
- Latency:
  - First beat is registered; `valid_out` rises the cycle after accept.
  - Subsequent beats: one per cycle while `ready_out`=1.
  - Next-step selection is a priority encoder over `nz` above the current `step_idx`; no idle cycles between skipped steps.
- Backpressure: while `valid_out && !ready_out`, all outputs hold stable.
- `last` is asserted iff no further step remains in the issue set.
- `lane_cnt` always equals popcount(`lane_mask`).
- Reset mid-operation: the operation is dropped, no further beats are issued, and the block returns to IDLE.
- `vld_mask`/`fmt_s` changes while not accepting: ignored.

Test Plan (TCK=4, MAX_INPUTS=32):
- FP16, `vld_mask`=0xFFFFFFFF, SKIP_EMPTY=1, `ready_out`=1 -> 2 beats in consecutive cycles, starting 1 cycle after accept:
  - step_idx 0, 1; `lane_mask` 0xF each; `lane_cnt` 4; `last` on step 1.
- FP32, `vld_mask`=0x00000101, SKIP_EMPTY=1 -> 1 beat: step_idx 0, `lane_mask` 0b0011... is not possible (odd lanes forced 0); required `lane_mask` 0b0101, `lane_cnt` 2, `last`=1.
- I4, `vld_mask`=0x0F0000F0:
  - SKIP_EMPTY=1 -> 2 beats: step_idx 1 and 6, `lane_mask` 0xF each, `last` on step 6.
  - SKIP_EMPTY=0 -> 8 beats, steps 0..7, masks 0,F,0,0,0,0,F,0.
- I8, `vld_mask`=0x55555555, `ready_out` low for 3 cycles on beat 1 -> beat 1 outputs stable for 4 cycles; sequence step 0..3, `lane_mask` 0xF each, then `last`.
- `vld_mask`=0 with FP16, then `fmt_s`=0xF -> 2 operations of 1 beat each: `lane_mask` 0, `last`=1; `fmt_err` 0 then 1.
- Two FP16 operations offered back-to-back: second accepted in the same cycle as the first's `last` handshake, with no gap in `valid_out`. Then assert `reset` during step 0 of a third operation -> `valid_out`=0 the next cycle and `ready_in`=1.

Source files
------------

// File: rtl/vx_tcu_drl_mask_seq.sv
// vx_tcu_drl_mask_seq: turns one vld_mask + format per operation into a stream of per-step TCK-lane masks
// in : clk, reset, valid_in, vld_mask, fmt_s, ready_out
// out: ready_in, valid_out, lane_mask, step_idx, last, lane_cnt, fmt_err
module vx_tcu_drl_mask_seq #(
  parameter int MAX_INPUTS = 32,
  parameter int N = 2,
  parameter int TCK = 2 * N,
  parameter int SKIP_EMPTY = 1,
  parameter int MAX_STEPS = MAX_INPUTS / TCK,
  localparam int SW = $clog2(MAX_STEPS),
  localparam int CW = $clog2(TCK + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [MAX_INPUTS-1:0] vld_mask,
  input  logic [3:0]            fmt_s,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [TCK-1:0]        lane_mask,
  output logic [SW-1:0]         step_idx,
  output logic                  last,
  output logic [CW-1:0]         lane_cnt,
  output logic                  fmt_err
);
  localparam logic [3:0] FMT_FP32 = 4'd0, FMT_FP16 = 4'd1, FMT_BF16 = 4'd2, FMT_FP8 = 4'd3,
                         FMT_BF8 = 4'd4, FMT_I8 = 4'd9, FMT_U8 = 4'd10, FMT_I4 = 4'd11, FMT_U4 = 4'd12;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  // cat: 0 = stride 4 with odd lanes off (FP32), 1 = stride 4, 2 = stride 2, 3 = stride 1
  logic [1:0]            cat_in, cat_r;
  logic                  err_in, acc, adv, done, found, more;
  logic [MAX_INPUTS-1:0] mask_r;
  logic [MAX_STEPS-1:0]  iss_r, iss_in, v;
  logic [SW-1:0]         nxt;
  logic [TCK-1:0]        lm;
  int                    from;
  function automatic int kof(input logic [1:0] c);
    return c == 2'd3 ? MAX_STEPS : c == 2'd2 ? MAX_STEPS / 2 : MAX_STEPS / 4;
  endfunction
  function automatic logic [TCK-1:0] lanes(input logic [MAX_INPUTS-1:0] m, input logic [1:0] c, input int s);
    logic [TCK-1:0] r;
    int st;
    st = c == 2'd3 ? 1 : c == 2'd2 ? 2 : 4;
    for (int i = 0; i < TCK; i++) r[i] = (c != 2'd0 || i % 2 == 0) && 1'(m >> (s * st * TCK + i * st));
    return r;
  endfunction
  // steps that will produce a beat; empty for unsupported formats so the single error beat path is taken
  function automatic logic [MAX_STEPS-1:0] iss(input logic [MAX_INPUTS-1:0] m, input logic [1:0] c, input logic e);
    logic [MAX_STEPS-1:0] r;
    for (int s = 0; s < MAX_STEPS; s++) r[s] = !e && s < kof(c) && (SKIP_EMPTY == 0 || |lanes(m, c, s));
    return r;
  endfunction
  assign valid_out = state == ISSUE;
  assign done      = valid_out && ready_out && last;
  assign adv       = valid_out && ready_out && !last;
  assign ready_in  = state == IDLE || done;
  assign acc       = valid_in && ready_in;
  always_comb begin
    err_in  = !(fmt_s inside {FMT_FP32, FMT_FP16, FMT_BF16, FMT_FP8, FMT_BF8, FMT_I8, FMT_U8, FMT_I4, FMT_U4});
    cat_in  = fmt_s == FMT_FP32 ? 2'd0 : (fmt_s inside {FMT_FP16, FMT_BF16}) ? 2'd1 :
              (fmt_s inside {FMT_I4, FMT_U4}) ? 2'd3 : 2'd2;
    iss_in  = iss(vld_mask, cat_in, err_in);
    v       = acc ? iss_in : iss_r;
    from    = acc ? 0 : int'(step_idx) + 1;
    found   = 1'b0;
    more    = 1'b0;
    nxt     = '0;
    // lowest pending step becomes the next beat; any second hit means this beat is not last
    for (int s = 0; s < MAX_STEPS; s++) begin
      if (v[s] && s >= from) begin
        more  = more || found;
        nxt   = found ? nxt : SW'(s);
        found = 1'b1;
      end
    end
    lm      = found ? lanes(acc ? vld_mask : mask_r, acc ? cat_in : cat_r, int'(nxt)) : '0;
    state_n = acc ? ISSUE : done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lane_mask <= '0;
      step_idx  <= '0;
      last      <= 1'b0;
      lane_cnt  <= '0;
      fmt_err   <= 1'b0;
      mask_r    <= '0;
      cat_r     <= '0;
      iss_r     <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        mask_r  <= vld_mask;
        cat_r   <= cat_in;
        iss_r   <= iss_in;
        fmt_err <= err_in;
      end
      if (acc || adv) begin
        lane_mask <= lm;
        step_idx  <= nxt;
        last      <= !more;
        lane_cnt  <= CW'($countones(lm));
      end else if (done) begin
        lane_mask <= '0;
        step_idx  <= '0;
        last      <= 1'b0;
        lane_cnt  <= '0;
        fmt_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vx_tcu_drl_mask_seq.sv
// tb_vx_tcu_drl_mask_seq: directed scoreboard bench for the lane-mask sequencer (dut0 SKIP_EMPTY=0, dut1 SKIP_EMPTY=1)
module tb_vx_tcu_drl_mask_seq;
  localparam logic [3:0] FP32 = 4'd0, FP16 = 4'd1, I8 = 4'd9, I4 = 4'd11;
  typedef struct packed {
    logic [3:0] lm;
    logic [2:0] si;
    logic       l;
    logic [2:0] cnt;
    logic       err;
  } beat_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in[2], ready_in[2], valid_out[2], ready_out[2], last[2], fmt_err[2];
  logic [31:0] vld_mask[2];
  logic [3:0]  fmt_s[2], lane_mask[2];
  logic [2:0]  step_idx[2], lane_cnt[2];
  beat_t       sb[2][$];
  int          cq[2][$];
  int          cyc = 0, vectors = 0, miss = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    vx_tcu_drl_mask_seq #(.MAX_INPUTS(32), .N(2), .SKIP_EMPTY(g)) u_dut (
      .clk(clk), .reset(reset), .valid_in(valid_in[g]), .ready_in(ready_in[g]),
      .vld_mask(vld_mask[g]), .fmt_s(fmt_s[g]), .valid_out(valid_out[g]), .ready_out(ready_out[g]),
      .lane_mask(lane_mask[g]), .step_idx(step_idx[g]), .last(last[g]), .lane_cnt(lane_cnt[g]),
      .fmt_err(fmt_err[g])
    );
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic expect_beat(input int d, input logic [3:0] lm, input int si, input logic l, input logic e, input int c);
    sb[d].push_back(beat_t'({lm, 3'(si), l, 3'($countones(lm)), e}));
    cq[d].push_back(c);
  endtask
  task automatic send(input int d, input logic [31:0] m, input logic [3:0] f, output int ac);
    int n;
    n = 0;
    vld_mask[d] = m;
    fmt_s[d] = f;
    valid_in[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (ready_in[d] !== 1'b1 && n < 100);
    if (ready_in[d] !== 1'b1) begin
      vectors++;
      miss++;
      $display("FAIL accept dut%0d: ready_in never rose within 100 cycles", d);
    end
    ac = cyc;
    @(posedge clk);
    #1;
    valid_in[d] = 1'b0;
    vld_mask[d] = ~m;
    fmt_s[d] = 4'hE;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain dut0 pending", sb[0].size(), 0);
    chk("drain dut1 pending", sb[1].size(), 0);
  endtask
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (valid_out[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          vectors++;
          miss++;
          $display("FAIL unexpected beat dut%0d: step %0d mask 0x%0h", d, step_idx[d], lane_mask[d]);
        end else begin
          chk($sformatf("beat dut%0d {mask,step,last,cnt,err}", d),
              32'({lane_mask[d], step_idx[d], last[d], lane_cnt[d], fmt_err[d]}), 32'(sb[d][0]));
          if (ready_out[d] === 1'b1) begin
            chk($sformatf("beat cycle dut%0d", d), cyc, cq[d][0]);
            void'(sb[d].pop_front());
            void'(cq[d].pop_front());
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ac, ac2;
    for (int d = 0; d < 2; d++) begin
      valid_in[d] = 1'b0;
      ready_out[d] = 1'b1;
      vld_mask[d] = '0;
      fmt_s[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset outs dut%0d", d),
          32'({valid_out[d], lane_mask[d], step_idx[d], last[d], lane_cnt[d], fmt_err[d]}), 0);
      chk($sformatf("reset ready_in dut%0d", d), 32'(ready_in[d]), 1);
    end
    @(posedge clk);
    #1;
    send(1, 32'hFFFF_FFFF, FP16, ac);
    expect_beat(1, 4'hF, 0, 1'b0, 1'b0, ac + 1);
    expect_beat(1, 4'hF, 1, 1'b1, 1'b0, ac + 2);
    drain();
    send(1, 32'h0000_0101, FP32, ac);
    expect_beat(1, 4'b0101, 0, 1'b1, 1'b0, ac + 1);
    drain();
    send(1, 32'h0F00_00F0, I4, ac);
    expect_beat(1, 4'hF, 1, 1'b0, 1'b0, ac + 1);
    expect_beat(1, 4'hF, 6, 1'b1, 1'b0, ac + 2);
    drain();
    send(0, 32'h0F00_00F0, I4, ac);
    for (int s = 0; s < 8; s++) expect_beat(0, (s == 1 || s == 6) ? 4'hF : 4'h0, s, s == 7, 1'b0, ac + 1 + s);
    drain();
    send(1, 32'h5555_5555, I8, ac);
    expect_beat(1, 4'hF, 0, 1'b0, 1'b0, ac + 1);
    expect_beat(1, 4'hF, 1, 1'b0, 1'b0, ac + 5);
    expect_beat(1, 4'hF, 2, 1'b0, 1'b0, ac + 6);
    expect_beat(1, 4'hF, 3, 1'b1, 1'b0, ac + 7);
    @(posedge clk);
    #1;
    ready_out[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_out[1] = 1'b1;
    drain();
    send(1, 32'h0000_0000, FP16, ac);
    expect_beat(1, 4'h0, 0, 1'b1, 1'b0, ac + 1);
    drain();
    send(1, 32'hFFFF_FFFF, 4'hF, ac);
    expect_beat(1, 4'h0, 0, 1'b1, 1'b1, ac + 1);
    drain();
    send(1, 32'hFFFF_FFFF, FP16, ac);
    expect_beat(1, 4'hF, 0, 1'b0, 1'b0, ac + 1);
    expect_beat(1, 4'hF, 1, 1'b1, 1'b0, ac + 2);
    send(1, 32'hFFFF_FFFF, FP16, ac2);
    chk("b2b accept cycle", ac2, ac + 2);
    expect_beat(1, 4'hF, 0, 1'b0, 1'b0, ac + 3);
    expect_beat(1, 4'hF, 1, 1'b1, 1'b0, ac + 4);
    drain();
    send(1, 32'hFFFF_FFFF, FP16, ac);
    expect_beat(1, 4'hF, 0, 1'b0, 1'b0, ac + 1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post-reset valid_out", 32'(valid_out[1]), 0);
    chk("post-reset ready_in", 32'(ready_in[1]), 1);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
